// File: rtl/keypad_scan4x4.sv
// 4x4 key matrix scanner: one-cold row drive, synchronised column read,
// per-key debounce and single press/release pulses.
module keypad_scan4x4 #(
   parameter logic [15:0] SCAN_DIV   = 16'd50000,
   parameter logic [3:0]  DEBOUNCE_N = 4'd4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down,
   output logic       key_rel
);

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   logic [3:0]  r_sync1;
   logic [3:0]  r_sync2;
   logic [15:0] r_div;
   logic [1:0]  r_row;
   logic [1:0]  w_row_nxt;
   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_cand;
   logic [1:0]  w_cand_nxt;
   logic [3:0]  r_deb;
   logic [3:0]  w_deb_nxt;
   logic [3:0]  r_code;
   logic [3:0]  w_code_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic        r_down;
   logic        w_down_nxt;
   logic        r_rel;
   logic        w_rel_nxt;

   logic        w_sample;
   logic        w_any;
   logic [1:0]  w_pcol;
   logic        w_cand_hi;
   logic [3:0]  w_deb_inc;
   logic        w_deb_done;
   logic        w_first_done;

   // Two-flop synchroniser on the asynchronous, pulled-up columns
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= col_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sample = (r_div == (SCAN_DIV - 16'd1));

   // Row dwell divider; the last cycle of each dwell is the sample point
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div <= 16'd0;
      end else if (w_sample) begin
         r_div <= 16'd0;
      end else begin
         r_div <= r_div + 16'd1;
      end
   end

   assign w_any        = (r_sync2 != 4'hF);
   assign w_cand_hi    = r_sync2[r_cand];
   assign w_deb_inc    = r_deb + 4'd1;
   assign w_deb_done   = (w_deb_inc == DEBOUNCE_N);
   assign w_first_done = (DEBOUNCE_N == 4'd1);

   // Lowest-numbered low column wins when several keys share the row
   always_comb begin
      w_pcol = 2'd0;
      if (!r_sync2[0]) begin
         w_pcol = 2'd0;
      end else if (!r_sync2[1]) begin
         w_pcol = 2'd1;
      end else if (!r_sync2[2]) begin
         w_pcol = 2'd2;
      end else if (!r_sync2[3]) begin
         w_pcol = 2'd3;
      end
   end

   // Next-state and next-output decisions, taken only at sample points
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_cand_nxt  = r_cand;
      w_deb_nxt   = r_deb;
      w_code_nxt  = r_code;
      w_valid_nxt = 1'b0;
      w_rel_nxt   = 1'b0;
      w_down_nxt  = r_down;
      case (r_state)
         SCAN: begin
            if (w_sample) begin
               if (!w_any) begin
                  w_row_nxt = r_row + 2'd1;
               end else begin
                  w_cand_nxt = w_pcol;
                  if (w_first_done) begin
                     w_code_nxt  = {r_row, w_pcol};
                     w_valid_nxt = 1'b1;
                     w_down_nxt  = 1'b1;
                     w_deb_nxt   = 4'd0;
                     w_state_nxt = HELD;
                  end else begin
                     w_deb_nxt   = 4'd1;
                     w_state_nxt = DEB_PRESS;
                  end
               end
            end
         end
         DEB_PRESS: begin
            if (w_sample) begin
               if (!w_cand_hi) begin
                  if (w_deb_done) begin
                     w_code_nxt  = {r_row, r_cand};
                     w_valid_nxt = 1'b1;
                     w_down_nxt  = 1'b1;
                     w_deb_nxt   = 4'd0;
                     w_state_nxt = HELD;
                  end else begin
                     w_deb_nxt = w_deb_inc;
                  end
               end else begin
                  // bounce: drop the candidate and move on
                  w_deb_nxt   = 4'd0;
                  w_row_nxt   = r_row + 2'd1;
                  w_state_nxt = SCAN;
               end
            end
         end
         HELD: begin
            if (w_sample && w_cand_hi) begin
               if (w_first_done) begin
                  w_rel_nxt   = 1'b1;
                  w_down_nxt  = 1'b0;
                  w_deb_nxt   = 4'd0;
                  w_row_nxt   = r_row + 2'd1;
                  w_state_nxt = SCAN;
               end else begin
                  w_deb_nxt   = 4'd1;
                  w_state_nxt = DEB_REL;
               end
            end
         end
         DEB_REL: begin
            if (w_sample) begin
               if (w_cand_hi) begin
                  if (w_deb_done) begin
                     w_rel_nxt   = 1'b1;
                     w_down_nxt  = 1'b0;
                     w_deb_nxt   = 4'd0;
                     w_row_nxt   = r_row + 2'd1;
                     w_state_nxt = SCAN;
                  end else begin
                     w_deb_nxt = w_deb_inc;
                  end
               end else begin
                  w_deb_nxt   = 4'd0;
                  w_state_nxt = HELD;
               end
            end
         end
         default: begin
            w_deb_nxt   = 4'd0;
            w_state_nxt = SCAN;
         end
      endcase
   end

   // FSM state, row index, candidate column and debounce count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= SCAN;
         r_row   <= 2'd0;
         r_cand  <= 2'd0;
         r_deb   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_cand  <= w_cand_nxt;
         r_deb   <= w_deb_nxt;
      end
   end

   // Registered outputs so pulses land the cycle after the deciding sample
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_code  <= 4'h0;
         r_valid <= 1'b0;
         r_down  <= 1'b0;
         r_rel   <= 1'b0;
      end else begin
         r_code  <= w_code_nxt;
         r_valid <= w_valid_nxt;
         r_down  <= w_down_nxt;
         r_rel   <= w_rel_nxt;
      end
   end

   assign row_out   = ~(4'b0001 << r_row);
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_down  = r_down;
   assign key_rel   = r_rel;

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Bench for keypad_scan4x4: modelled key matrix, table-driven
// press/release steps plus bounce, reset and row-rotation sequences.
module tb_keypad_scan4x4;

   logic       clk;
   logic       rst_n;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       key_rel;
   logic [15:0] keys;

   int n_pass;
   int n_total;
   int valid_cnt;
   int rel_cnt;
   int bad_cnt;
   logic [3:0] rel_row;

   typedef struct {
      logic [15:0] keys;
      int          cycles;
      int          exp_valid;
      int          exp_rel;
      logic [3:0]  exp_code;
      logic        exp_down;
      logic        chk_row;
      logic [3:0]  exp_row;
   } vec_t;

   vec_t vt[11];

   keypad_scan4x4 #(
      .SCAN_DIV   (16'd8),
      .DEBOUNCE_N (4'd3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .key_rel   (key_rel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix model: column low iff a pressed key sits on a driven row
   always_comb begin
      col_in = 4'hF;
      for (int rr = 0; rr < 4; rr++) begin
         if (!row_out[rr]) begin
            for (int cc = 0; cc < 4; cc++) begin
               if (keys[rr*4+cc]) col_in[cc] = 1'b0;
            end
         end
      end
   end

   // Pulse counters and invariants, sampled away from the clock edge
   always @(negedge clk) begin
      if (key_valid) valid_cnt++;
      if (key_rel) begin
         rel_cnt++;
         rel_row = row_out;
      end
      if ($countones(~row_out) != 1) bad_cnt++;
      if (key_valid && key_rel) bad_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_row(input logic [3:0] pat);
      int n;
      n = 0;
      while (row_out == pat && n < 64) begin
         @(negedge clk);
         n++;
      end
      while (row_out != pat && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("wait_row", {28'd0, row_out}, {28'd0, pat});
   endtask

   initial begin
      int v0;
      int r0;
      n_pass = 0;
      n_total = 0;
      valid_cnt = 0;
      rel_cnt = 0;
      bad_cnt = 0;
      rel_row = 4'hF;
      keys = 16'h0;
      rst_n = 1'b0;

      vt[0]  = '{16'h0000,  40, 0, 0, 4'h0, 1'b0, 1'b0, 4'h0};
      vt[1]  = '{16'h0200, 120, 1, 0, 4'h9, 1'b1, 1'b0, 4'h0};
      vt[2]  = '{16'h0000,  40, 0, 1, 4'h9, 1'b0, 1'b1, 4'b0111};
      vt[3]  = '{16'h0050, 120, 1, 0, 4'h4, 1'b1, 1'b0, 4'h0};
      vt[4]  = '{16'h0040, 140, 1, 1, 4'h6, 1'b1, 1'b0, 4'h0};
      vt[5]  = '{16'h0000,  40, 0, 1, 4'h6, 1'b0, 1'b1, 4'b1011};
      vt[6]  = '{16'h8000, 120, 1, 0, 4'hF, 1'b1, 1'b0, 4'h0};
      vt[7]  = '{16'h8001, 100, 0, 0, 4'hF, 1'b1, 1'b0, 4'h0};
      vt[8]  = '{16'h0001, 120, 1, 1, 4'h0, 1'b1, 1'b0, 4'h0};
      vt[9]  = '{16'h0000,  40, 0, 1, 4'h0, 1'b0, 1'b1, 4'b1101};
      vt[10] = '{16'h0000, 200, 0, 0, 4'h0, 1'b0, 1'b0, 4'h0};

      cyc(3);
      chk("rst_row",   {28'd0, row_out}, 32'hE);
      chk("rst_code",  {28'd0, key_code}, 32'h0);
      chk("rst_valid", {31'd0, key_valid}, 32'h0);
      chk("rst_down",  {31'd0, key_down}, 32'h0);
      chk("rst_rel",   {31'd0, key_rel}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         v0 = valid_cnt;
         r0 = rel_cnt;
         keys = vt[i].keys;
         cyc(vt[i].cycles);
         chk($sformatf("v%0d_valid", i), valid_cnt - v0, vt[i].exp_valid);
         chk($sformatf("v%0d_rel", i), rel_cnt - r0, vt[i].exp_rel);
         chk($sformatf("v%0d_code", i), {28'd0, key_code},
             {28'd0, vt[i].exp_code});
         chk($sformatf("v%0d_down", i), {31'd0, key_down},
             {31'd0, vt[i].exp_down});
         if (vt[i].chk_row)
            chk($sformatf("v%0d_relrow", i), {28'd0, rel_row},
                {28'd0, vt[i].exp_row});
      end

      // Bounce on row0/col3: one low sample, one high, then steady
      keys = 16'h0;
      wait_row(4'b1110);
      v0 = valid_cnt;
      keys = 16'h0008;
      cyc(8);
      chk("bnc_frozen", {28'd0, row_out}, 32'hE);
      keys = 16'h0;
      cyc(8);
      chk("bnc_adv", {28'd0, row_out}, 32'hD);
      chk("bnc_nopulse", valid_cnt - v0, 0);
      keys = 16'h0008;
      cyc(120);
      chk("bnc_valid", valid_cnt - v0, 1);
      chk("bnc_code", {28'd0, key_code}, 32'h3);
      r0 = rel_cnt;
      keys = 16'h0;
      cyc(40);
      chk("bnc_rel", rel_cnt - r0, 1);

      // Reset while debouncing a press on row1/col1
      wait_row(4'b1101);
      v0 = valid_cnt;
      r0 = rel_cnt;
      keys = 16'h0020;
      cyc(12);
      rst_n = 1'b0;
      cyc(1);
      chk("mrst_row",   {28'd0, row_out}, 32'hE);
      chk("mrst_code",  {28'd0, key_code}, 32'h0);
      chk("mrst_valid", {31'd0, key_valid}, 32'h0);
      chk("mrst_down",  {31'd0, key_down}, 32'h0);
      chk("mrst_rel",   {31'd0, key_rel}, 32'h0);
      rst_n = 1'b1;
      cyc(120);
      chk("mrst_redet", valid_cnt - v0, 1);
      chk("mrst_code5", {28'd0, key_code}, 32'h5);
      chk("mrst_down1", {31'd0, key_down}, 32'h1);
      keys = 16'h0;
      cyc(40);
      chk("mrst_rel1", rel_cnt - r0, 1);

      // Idle row rotation: 8-cycle dwell per row
      wait_row(4'b1110);
      cyc(4);
      chk("rot_r0", {28'd0, row_out}, 32'hE);
      cyc(8);
      chk("rot_r1", {28'd0, row_out}, 32'hD);
      cyc(8);
      chk("rot_r2", {28'd0, row_out}, 32'hB);
      cyc(8);
      chk("rot_r3", {28'd0, row_out}, 32'h7);
      cyc(8);
      chk("rot_wrap", {28'd0, row_out}, 32'hE);

      chk("invariants", bad_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
